slice_rr_arbiter: RTL and testbench
===================================

// Module: slice_rr_arbiter
// PURPOSE
// - Shares one downstream resource (e.g. a counter/datapath unit) among NUM_REQ requesters.
// - Grants are round-robin; each grant is bounded by a SLICE_LEN-cycle time slice.
// - A requester releases the resource early with done[i]; otherwise it is pre-empted at slice end.
// - Sits between the requesting engines and the shared unit's enable/select mux.
// PARAMETERS
// - NUM_REQ   4  number of requesters, 2..16
// - SLICE_LEN 8  max cycles per grant, 1..2**CNT_W-1
// - CNT_W     8  slice counter width
// - ID_W      2  width of grant_id, = clog2(NUM_REQ)
// PORTS
// - sys_clk        in   1        clock, rising edge
// - rst            in   1        reset, asynchronous, active-high
// - req            in   NUM_REQ  level request per requester
// - done           in   NUM_REQ  1-cycle release pulse; only done[grant_id] has effect
// - grant          out  NUM_REQ  one-hot grant, registered
// - grant_valid    out  1        OR of grant, registered
// - grant_id       out  ID_W     index of granted requester; 0 when !grant_valid
// - slice_cnt      out  CNT_W    cycles elapsed in current grant (0 on the grant cycle)
// - slice_expired  out  1        1-cycle pulse: current grant pre-empted by slice end
// BEHAVIOUR
// - Reset: state=IDLE, grant=0, grant_valid=0, grant_id=0, slice_cnt=0, slice_expired=0, rr_ptr=0.
// - FSM states: IDLE, GRANT, GAP. All outputs are registers.
// - IDLE: if |req, pick winner = first set req[k] scanning k = rr_ptr, rr_ptr+1, ... mod NUM_REQ;
//   next cycle state=GRANT, grant=onehot(winner), grant_id=winner, slice_cnt=0. Latency req->grant: 1 cycle.
// - GRANT: each cycle slice_cnt increments (saturates at SLICE_LEN-1). Exit to GAP on the first of:
//   a) done[grant_id]=1, b) req[grant_id]=0, c) slice_cnt==SLICE_LEN-1 (pre-emption).
//   Exit cause (c) with neither a) nor b) in the same cycle -> slice_expired=1 for the GAP cycle.
//   Simultaneous (a|b) and (c): treated as normal release, slice_expired=0.
// - GAP: grant=0, grant_valid=0, grant_id=0, slice_cnt=0 for exactly 1 cycle (hand-over turnaround);
//   rr_ptr <= (last grant_id + 1) mod NUM_REQ; then IDLE arbitration applies in the GAP cycle itself,
//   so the next grant appears on the cycle after GAP. Min grant-to-grant spacing: 1 idle cycle.
// - Pre-empted requester keeps req high -> rejoins round-robin; gets resource again only after all
//   other active requesters have had a turn.
// - done[] for non-granted requesters and done while IDLE/GAP: ignored.
// - SLICE_LEN=1: every grant lasts exactly 1 cycle; slice_expired pulses unless done/req-drop coincides.
// - rr_ptr wraps NUM_REQ-1 -> 0; never changes while in GRANT.
// - rst asserted mid-grant: outputs drop to reset values asynchronously; arbitration restarts at rr_ptr=0.
// - Invariants: grant is one-hot or zero; grant_valid == |grant; grant_id matches grant.
// STRUCTURE
// - Header slice_arb_defs.vh: state encodings (ST_IDLE=2'd0, ST_GRANT=2'd1, ST_GAP=2'd2), default
//   SLICE_LEN/CNT_W constants shared with the resource wrapper.
// - Sub-module rr_priority_pick (combinational): inputs req, rr_ptr; outputs any, winner index.
// - Top: FSM + slice counter + rr_ptr register + output registers.
// TESTING
// - Reset then req=4'b0000 for 20 cycles -> grant_valid stays 0, slice_cnt stays 0.
// - req=4'b0100 at cycle 0 -> grant=4'b0100, grant_id=2 at cycle 1; done[2] at cycle 4 -> grant=0 cycle 5 (GAP).
// - req=4'b1111 held, no done, SLICE_LEN=8 -> grants 0,1,2,3,0 each 8 cycles, 1-cycle gaps,
//   slice_expired pulses in every GAP cycle.
// - done[1] and slice_cnt==7 same cycle while grant_id=1 -> GAP with slice_expired=0, next grant id 2.
// - Granted to 3, req[3] dropped at slice_cnt=2 -> GAP next cycle, rr_ptr wraps to 0, req=4'b0011 -> grant_id=0.
// - rst pulse while grant_id=2, slice_cnt=5 -> all outputs 0 immediately; after release req=4'b0100 -> grant_id=2 1 cycle later.

Source files
------------

// File: rtl/slice_rr_arbiter_pkg.sv
// Shared definitions for the time-sliced round-robin arbiter and the resource wrapper.
package slice_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_t;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_SLICE_LEN = 8;
  localparam int DEF_CNT_W     = 8;

endpackage

// File: rtl/slice_rr_arbiter_rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after rr_ptr wins.
module rr_priority_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  int idx;

  // Scan from the farthest offset down so the nearest request to rr_ptr is written last.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req[idx]) begin
        winner = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/slice_rr_arbiter.sv
// Round-robin arbiter with a bounded time slice per grant and a one-cycle hand-over gap.
module slice_rr_arbiter
  import slice_rr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int SLICE_LEN = DEF_SLICE_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic [CNT_W-1:0]   slice_cnt,
  output logic               slice_expired
);

  arb_state_t         state_reg, state_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic               valid_reg, valid_next;
  logic [ID_W-1:0]    id_reg, id_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               expired_reg, expired_next;
  logic [ID_W-1:0]    rr_ptr_reg, rr_ptr_next;

  logic               pick_any;
  logic [ID_W-1:0]    pick_winner;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               arb_en;
  logic               release_hit;
  logic               slice_end;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_reg),
    .any    (pick_any),
    .winner (pick_winner)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign pick_onehot[gi] = (pick_winner == ID_W'(gi));
    end
  endgenerate

  always_comb begin
    state_next   = state_reg;
    grant_next   = '0;
    valid_next   = 1'b0;
    id_next      = '0;
    cnt_next     = '0;
    expired_next = 1'b0;
    rr_ptr_next  = rr_ptr_reg;
    arb_en       = 1'b0;
    release_hit  = 1'b0;
    slice_end    = 1'b0;

    case (state_reg)
      ST_IDLE: arb_en = 1'b1;
      ST_GRANT: begin
        release_hit = done[id_reg] | ~req[id_reg];
        slice_end   = (cnt_reg == CNT_W'(SLICE_LEN - 1));
        if (release_hit || slice_end) begin
          state_next   = ST_GAP;
          // A voluntary release in the last slice cycle is not a pre-emption.
          expired_next = slice_end & ~release_hit;
          rr_ptr_next  = (id_reg == ID_W'(NUM_REQ - 1)) ? '0 : id_reg + ID_W'(1);
        end else begin
          grant_next = grant_reg;
          valid_next = 1'b1;
          id_next    = id_reg;
          cnt_next   = cnt_reg + CNT_W'(1);
        end
      end
      ST_GAP:  arb_en = 1'b1;
      default: state_next = ST_IDLE;
    endcase

    // GAP arbitrates with the already-advanced pointer so the next grant follows immediately.
    if (arb_en) begin
      if (pick_any) begin
        state_next = ST_GRANT;
        grant_next = pick_onehot;
        valid_next = 1'b1;
        id_next    = pick_winner;
      end else begin
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      grant_reg   <= '0;
      valid_reg   <= 1'b0;
      id_reg      <= '0;
      cnt_reg     <= '0;
      expired_reg <= 1'b0;
      rr_ptr_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      valid_reg   <= valid_next;
      id_reg      <= id_next;
      cnt_reg     <= cnt_next;
      expired_reg <= expired_next;
      rr_ptr_reg  <= rr_ptr_next;
    end
  end

  assign grant         = grant_reg;
  assign grant_valid   = valid_reg;
  assign grant_id      = id_reg;
  assign slice_cnt     = cnt_reg;
  assign slice_expired = expired_reg;

endmodule

// File: tb/tb_slice_rr_arbiter.sv
// Directed bench for slice_rr_arbiter (NUM_REQ=4, SLICE_LEN=8).
module tb_slice_rr_arbiter;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [7:0] slice_cnt;
  logic       slice_expired;

  int checks   = 0;
  int failures = 0;

  slice_rr_arbiter #(
    .NUM_REQ   (4),
    .SLICE_LEN (8),
    .CNT_W     (8),
    .ID_W      (2)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .req           (req),
    .done          (done),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_id      (grant_id),
    .slice_cnt     (slice_cnt),
    .slice_expired (slice_expired)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eg, input logic ev,
                           input logic [1:0] eid, input logic [7:0] ecnt, input logic eexp);
    cmp({tag, ".grant"}, 32'(grant), 32'(eg));
    cmp({tag, ".valid"}, 32'(grant_valid), 32'(ev));
    cmp({tag, ".id"}, 32'(grant_id), 32'(eid));
    cmp({tag, ".cnt"}, 32'(slice_cnt), 32'(ecnt));
    cmp({tag, ".expired"}, 32'(slice_expired), 32'(eexp));
    $display("txn %s: grant=%b valid=%0d id=%0d cnt=%0d expired=%0d",
             tag, grant, grant_valid, grant_id, slice_cnt, slice_expired);
  endtask

  int seq[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    step();
    step();
    check_all("reset", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    rst = 1'b0;

    // No requests: nothing is ever granted.
    for (int i = 0; i < 20; i++) begin
      step();
      cmp("idle.valid", 32'(grant_valid), 32'd0);
      cmp("idle.cnt", 32'(slice_cnt), 32'd0);
    end

    // Single requester, early release with done.
    req = 4'b0100;
    step();
    check_all("single.c1", 4'b0100, 1'b1, 2'd2, 8'd0, 1'b0);
    step();
    check_all("single.c2", 4'b0100, 1'b1, 2'd2, 8'd1, 1'b0);
    step();
    check_all("single.c3", 4'b0100, 1'b1, 2'd2, 8'd2, 1'b0);
    step();
    check_all("single.c4", 4'b0100, 1'b1, 2'd2, 8'd3, 1'b0);
    done = 4'b0100;
    step();
    check_all("single.gap", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    done = 4'b0000;
    req  = 4'b0000;
    step();
    check_all("single.idle", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);

    // Reset restores rr_ptr to 0 before the full round-robin pass.
    rst = 1'b1;
    step();
    rst = 1'b0;

    // All requesting: full slices, pre-emption pulse in every gap; stray done[] ignored.
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 8; c++) begin
        step();
        check_all($sformatf("rr.g%0d.c%0d", g, c), 4'(1 << seq[g]), 1'b1, 2'(seq[g]), 8'(c), 1'b0);
        done = (g == 0 && c == 3) ? 4'b1110 : 4'b0000;
      end
      step();
      check_all($sformatf("rr.gap%0d", g), 4'b0000, 1'b0, 2'd0, 8'd0, 1'b1);
    end

    // done coinciding with the last slice cycle counts as a normal release.
    for (int c = 0; c < 8; c++) begin
      step();
      check_all($sformatf("coinc.c%0d", c), 4'b0010, 1'b1, 2'd1, 8'(c), 1'b0);
    end
    done = 4'b0010;
    step();
    check_all("coinc.gap", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    done = 4'b0000;
    step();
    check_all("coinc.next", 4'b0100, 1'b1, 2'd2, 8'd0, 1'b0);

    // Grant 3, drop req[3] at cnt=2: pointer wraps, requester 0 wins next.
    req = 4'b1000;
    step();
    check_all("drop.gap0", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step();
      check_all($sformatf("drop.g3.c%0d", c), 4'b1000, 1'b1, 2'd3, 8'(c), 1'b0);
    end
    req = 4'b0011;
    step();
    check_all("drop.gap1", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    step();
    check_all("wrap.g0", 4'b0001, 1'b1, 2'd0, 8'd0, 1'b0);

    // Asynchronous reset mid-grant, then re-arbitration from rr_ptr=0.
    req = 4'b0100;
    step();
    check_all("rst.gap", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      step();
      check_all($sformatf("rst.g2.c%0d", c), 4'b0100, 1'b1, 2'd2, 8'(c), 1'b0);
    end
    rst = 1'b1;
    #1;
    check_all("rst.async", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    step();
    check_all("rst.held", 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    rst = 1'b0;
    step();
    check_all("rst.regrant", 4'b0100, 1'b1, 2'd2, 8'd0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
